// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the core-to-memory responder and its storage.
// Request/response are flat packed structs so they route as single buses.
package dbus_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam int unsigned WORD_BYTES = 8;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input strobe_t     strobe);
        logic [63:0] res;
        res = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (strobe[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_responder_dsram.sv
// Single-port 64-bit word store: combinational read, byte-strobed synchronous write.
// Contents are deliberately not reset.
module dsram
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  strobe_t       strobe,
    input  logic [IW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= byte_merge(mem[idx], wdata, strobe);
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave: captures one request, waits LATENCY cycles, responds for one cycle.
// Latency LATENCY+1 from acceptance; dropping valid while waiting aborts the request.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       err
);

    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);
    localparam logic [3:0]  LAT4    = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          accept;

    logic [IW-1:0] idx_q;
    logic          in_range_q;
    strobe_t       strobe_q;
    logic [63:0]   data_q;

    logic [63:0]   offset;
    logic [63:0]   word;
    logic          in_range;
    logic [63:0]   rdata;
    logic          mem_we;
    logic          unused_bits;

    // Range is decided once at capture so later request churn cannot affect it.
    assign offset   = dreq.addr - BASE_ADDR;
    assign word     = {3'b000, offset[63:3]};
    assign in_range = (dreq.addr >= BASE_ADDR) && (word < DEPTH_W);

    assign unused_bits = ^{dreq.size, offset[2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dreq.valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT4;
                    state_nxt = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            in_range_q <= 1'b0;
            strobe_q   <= '0;
            data_q     <= '0;
        end else if (accept) begin
            idx_q      <= word[IW-1:0];
            in_range_q <= in_range;
            strobe_q   <= dreq.strobe;
            data_q     <= dreq.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == RESP && !in_range_q) begin
            err <= 1'b1;
        end
    end

    assign busy   = (state != IDLE);
    assign mem_we = (state == RESP) && in_range_q && (strobe_q != '0);

    // Read data is the pre-write word: the write lands on the edge closing RESP.
    always_comb begin
        dresp = '0;
        if (state == RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = in_range_q ? rdata : 64'd0;
        end
    end

    dsram #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_dsram (
        .clk    (clk),
        .we     (mem_we),
        .strobe (strobe_q),
        .idx    (idx_q),
        .wdata  (data_q),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench: vector table on a LATENCY=2 instance plus abort/reset/back-to-back sequences.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int unsigned D    = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    dbus_req_t  dreq, dreq0;
    dbus_resp_t dresp, dresp0;
    logic       busy, err, busy0, err0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dbus_responder #(.DEPTH(D), .LATENCY(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .busy(busy), .err(err)
    );

    dbus_responder #(.DEPTH(D), .LATENCY(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0), .busy(busy0), .err(err0)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        chk_data;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [63:0] addr, input logic [7:0] strobe,
                                input logic [63:0] data, input logic chk_data,
                                input logic [63:0] exp_data, input logic exp_err);
        vec_t v;
        v.addr = addr; v.strobe = strobe; v.data = data;
        v.chk_data = chk_data; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance; scrambles request fields while waiting.
    task automatic txn(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data,
                       output logic [63:0] rdata, output int lat, output logic aok);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = MSIZE_D;
        dreq.strobe = strobe;
        dreq.data   = data;
        @(posedge clk);
        lat   = -1;
        rdata = '0;
        aok   = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (dresp.data_ok) begin
                lat   = n;
                rdata = dresp.data;
                aok   = dresp.addr_ok;
                break;
            end
            if (n == 1) begin
                dreq.addr   = BASE + 64'($urandom_range(0, D - 1)) * 8;
                dreq.data   = {$urandom, $urandom};
                dreq.strobe = 8'($urandom);
            end
        end
        dreq.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        int          lat;
        logic        aok;
        logic        seen;

        dreq  = '0;
        dreq0 = '0;

        vecs.push_back(mk(BASE,          8'hFF, 64'h0000_0000_0000_00FF, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(BASE,          8'h00, 64'h0,                   1'b1, 64'h0000_0000_0000_00FF, 1'b0));
        vecs.push_back(mk(BASE + 8,      8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(BASE + 8,      8'h0F, 64'hAABB_CCDD_EEFF_0011, 1'b1, 64'h1122_3344_5566_7788, 1'b0));
        vecs.push_back(mk(BASE + 8,      8'h00, 64'h0,                   1'b1, 64'h1122_3344_EEFF_0011, 1'b0));
        vecs.push_back(mk(BASE + 12,     8'h00, 64'h0,                   1'b1, 64'h1122_3344_EEFF_0011, 1'b0));
        vecs.push_back(mk(BASE + 16,     8'hFF, 64'h0,                   1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(BASE + 16,     8'h81, 64'hA1B2_C3D4_E5F6_0718, 1'b1, 64'h0, 1'b0));
        vecs.push_back(mk(BASE + 16,     8'h00, 64'h0,                   1'b1, 64'hA100_0000_0000_0018, 1'b0));
        vecs.push_back(mk(BASE + 8*15,   8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(BASE + 8*15,   8'h00, 64'h0,                   1'b1, 64'h0123_4567_89AB_CDEF, 1'b0));
        vecs.push_back(mk(BASE + 8*D,    8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(BASE,          8'h00, 64'h0,                   1'b1, 64'h0000_0000_0000_00FF, 1'b1));
        vecs.push_back(mk(BASE + 8*D,    8'h00, 64'h0,                   1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(BASE - 8,      8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(BASE + 8*15,   8'h00, 64'h0,                   1'b1, 64'h0123_4567_89AB_CDEF, 1'b1));

        repeat (2) @(negedge clk);
        chk("reset busy",    64'(busy),          64'd0);
        chk("reset err",     64'(err),           64'd0);
        chk("reset addr_ok", 64'(dresp.addr_ok), 64'd0);
        chk("reset data_ok", 64'(dresp.data_ok), 64'd0);
        chk("reset data",    dresp.data,         64'd0);
        chk("reset busy0",   64'(busy0),         64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].addr, vecs[i].strobe, vecs[i].data, rd, lat, aok);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d addr_ok", i), 64'(aok), 64'd1);
            if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d data_ok after", i), 64'(dresp.data_ok), 64'd0);
            chk($sformatf("vec%0d busy after", i), 64'(busy), 64'd0);
            chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].exp_err));
        end

        // Sticky err survives idle cycles and clears only on reset.
        repeat (3) @(negedge clk);
        chk("err sticky", 64'(err), 64'd1);
        reset = 1'b1;
        #1;
        chk("err cleared by reset", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort: write request withdrawn during WAIT.
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = BASE;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h5555_5555_5555_5555;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy in wait", 64'(busy), 64'd1);
        dreq.valid = 1'b0;
        @(negedge clk);
        chk("abort busy next", 64'(busy), 64'd0);
        seen = dresp.data_ok;
        repeat (4) begin
            @(negedge clk);
            seen = seen | dresp.data_ok;
        end
        chk("abort no data_ok", 64'(seen), 64'd0);
        chk("abort err", 64'(err), 64'd0);
        txn(BASE, 8'h00, 64'h0, rd, lat, aok);
        chk("abort word unchanged", rd, 64'h0000_0000_0000_00FF);

        // Reset asserted in the second WAIT cycle cancels the write.
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = BASE;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h7777_7777_7777_7777;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst-wait busy",    64'(busy),          64'd0);
        chk("rst-wait addr_ok", 64'(dresp.addr_ok), 64'd0);
        chk("rst-wait data_ok", 64'(dresp.data_ok), 64'd0);
        dreq.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        txn(BASE, 8'h00, 64'h0, rd, lat, aok);
        chk("rst-wait latency", 64'(lat), 64'd3);
        chk("rst-wait word unchanged", rd, 64'h0000_0000_0000_00FF);

        // LATENCY=0 with valid held: response every other cycle.
        @(negedge clk);
        dreq0.valid  = 1'b1;
        dreq0.addr   = BASE + 8;
        dreq0.size   = MSIZE_D;
        dreq0.strobe = 8'hFF;
        dreq0.data   = 64'h0F0E_0D0C_0B0A_0908;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk($sformatf("b2b cycle%0d data_ok", n), 64'(dresp0.data_ok), 64'(n % 2));
            if (n == 3) chk("b2b data", dresp0.data, 64'h0F0E_0D0C_0B0A_0908);
        end
        dreq0.valid = 1'b0;
        @(negedge clk);
        chk("b2b busy after", 64'(busy0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
